spi_master_sclk_gen: RTL and testbench
======================================

# spi_master_sclk_gen

Parametrised SCLK generator for the SPI master that replaces the fixed 8-bit clock generator. It has a configurable divider width and supports all four CPOL/CPHA modes. It counts a programmed number of bits and returns SCLK to its idle level on completion or abort. It sits between the SPI master controller FSM and the TX/RX shift registers, and provides the edge, sample and shift strobes that drive those registers.

## Interface
Parameters:
- DIV_WIDTH, 16: width of the half-period divider.
- BITS_WIDTH, 6: width of the bit-count input.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_div  in  DIV_WIDTH  half-period minus one, in clk cycles.
- clk_div_valid  in  1  loads clk_div into counter_trgt.
- cpol  in  1  idle SCLK level.
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- num_bits  in  BITS_WIDTH  bits per transfer, captured on start.
- start  in  1  single-cycle transfer request; honoured only in IDLE.
- stop  in  1  abort request; honoured only in RUN.
- spi_clk  out  1  SCLK (registered).
- spi_rise / spi_fall  out  1  asserted in the cycle whose clock edge makes spi_clk rise or fall.
- sample  out  1  RX sample strobe, qualified edge.
- shift  out  1  TX shift strobe, qualified edge.
- busy  out  1  high in RUN and STOPPING.
- done  out  1  single-cycle completion or abort pulse.
- aborted  out  1  valid with done; 1 if ended by stop.
- counter_trgt  out  DIV_WIDTH  currently programmed divider.

## Operation
- States (in shared package): IDLE, RUN, STOPPING.
- **Reset values:** state IDLE, spi_clk 0, counter 0, counter_trgt 0, all strobes 0, busy 0, done 0, aborted 0.
- **counter_trgt:** updated by clk_div_valid in any state. The value in use by the divider (div_q) and cpol, cpha and num_bits are captured on start. Changes during RUN take effect at the next transfer.
- **IDLE:**
  - spi_clk <= cpol every cycle.
  - start with num_bits != 0 -> RUN, counter 0, edge count 0.
  - start with num_bits == 0 -> stay IDLE; done=1, aborted=0 next cycle.
- **RUN, half-period counter:** counter increments each cycle. When counter == div_q: counter -> 0, spi_clk toggles, and spi_rise or spi_fall is asserted for that cycle. The edge is leading if odd-numbered (1st, 3rd, ...) and trailing otherwise.
- **RUN, sample strobe:** cpha=0 -> leading edges; cpha=1 -> trailing edges. Always exactly num_bits pulses.
- **RUN, shift strobe:**
  - cpha=1 -> leading edges, num_bits pulses.
  - cpha=0 -> trailing edges except the final one, num_bits-1 pulses. The first bit is driven by the datapath on start.
- **RUN, completion:** after edge 2*num_bits -> IDLE; done=1, aborted=0 in the next cycle. SCLK is then at cpol by construction.
- **stop in RUN:**
  - If the same cycle carries an edge strobe, that edge completes normally first.
  - If spi_clk == cpol_q afterwards -> IDLE, done=1, aborted=1 next cycle.
  - Otherwise -> STOPPING.
- **STOPPING:** counts to div_q and toggles spi_clk back to cpol_q, asserting spi_rise or spi_fall but never sample or shift. Then -> IDLE, done=1, aborted=1.
- **Ignored requests:** start outside IDLE, and stop outside RUN.
- **rst mid-transfer:** immediate return to reset values. spi_clk goes to 0 regardless of cpol. No done pulse.

## Timing
- Half-period is div_q+1 clk cycles. SCLK frequency is f_clk/(2*(div_q+1)). div_q=0 gives f_clk/2.
- **Latency:** start sampled at cycle 0 -> busy=1 at cycle 1, first edge strobe at cycle 1+div_q, first spi_clk change at cycle 2+div_q.
- **Transfer length:** the last edge strobe is at cycle 2*num_bits*(div_q+1). done is asserted 1 cycle later, the same cycle busy falls.
- All outputs are registered except spi_rise, spi_fall, sample and shift. These four are decoded from registered state, with no input-to-output combinational path.
- Back-to-back transfers: a start in the done cycle is accepted.

## Structure
- Package spi_master_pkg holds:
  - the state enum (sclk_state_e: IDLE, RUN, STOPPING);
  - the spi_mode_t struct {cpol, cpha};
  - constants for the default DIV_WIDTH and BITS_WIDTH.
- One sub-module, spi_master_divcnt, holds the DIV_WIDTH half-period counter with terminal-count output and clear. The FSM, edge counter (BITS_WIDTH+1 bits) and strobe decode stay in the top.

## Test plan
- Mode 0, div 0, N=1, start at cycle 0:
  - cycle 1: spi_rise, sample;
  - cycle 2: spi_fall, no shift;
  - cycle 3: done=1, aborted=0, spi_clk=0.
- Mode 3, div 3, N=8: exactly 16 edges spaced 4 cycles apart, 8 sample pulses on rising edges, 8 shift pulses on falling edges, spi_clk idles 1, done at cycle 65.
- Mode 1, div 2, N=4, stop asserted when spi_clk=1 mid-half-period: STOPPING, one spi_fall without sample or shift, then done=1, aborted=1, spi_clk=0.
- clk_div_valid with 5 during a div=1 transfer: counter_trgt reads 5 next cycle, current transfer keeps a 2-cycle half-period, next transfer uses 6.
- start with num_bits=0 -> done at cycle 1, no edges. start while busy -> ignored. stop in IDLE -> no effect.
- rst asserted mid-transfer with cpol=1: next cycle all outputs at reset values, spi_clk=0, no done. After release and one idle cycle, spi_clk=1.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI master clocking slice.
package spi_master_pkg;

  localparam int unsigned DefaultDivWidth  = 16;
  localparam int unsigned DefaultBitsWidth = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } sclk_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_master_sclk_gen_if.sv
// Control/status bundle between the SPI master controller and the SCLK generator.
interface spi_master_sclk_gen_if
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DefaultDivWidth,
  parameter int unsigned BITS_WIDTH = DefaultBitsWidth
);
  logic [DIV_WIDTH-1:0]  clk_div;
  logic                  clk_div_valid;
  logic                  cpol;
  logic                  cpha;
  logic [BITS_WIDTH-1:0] num_bits;
  logic                  start;
  logic                  stop;
  logic                  spi_clk;
  logic                  spi_rise;
  logic                  spi_fall;
  logic                  sample;
  logic                  shift;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [DIV_WIDTH-1:0]  counter_trgt;

  // Controller side.
  modport master (
    output clk_div, clk_div_valid, cpol, cpha, num_bits, start, stop,
    input  spi_clk, spi_rise, spi_fall, sample, shift, busy, done, aborted, counter_trgt
  );

  // Generator side.
  modport slave (
    input  clk_div, clk_div_valid, cpol, cpha, num_bits, start, stop,
    output spi_clk, spi_rise, spi_fall, sample, shift, busy, done, aborted, counter_trgt
  );
endinterface

// File: rtl/spi_master_divcnt.sv
// Half-period counter: counts 0..trgt_i while enabled, flags terminal count.
module spi_master_divcnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] trgt_i,
  output logic             tc_o
);
  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == trgt_i);

  // Wrap on terminal count; park at zero when disabled or cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i || tc_o) cnt_d = '0;
    else                        cnt_d = cnt_q + Width'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master_sclk_gen.sv
// SCLK generator: divider, bit/edge counting, CPOL/CPHA strobe decode, stop handling.
module spi_master_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DefaultDivWidth,
  parameter int unsigned BITS_WIDTH = DefaultBitsWidth
) (
  input logic                  clk,
  input logic                  rst,
  spi_master_sclk_gen_if.slave bus
);
  sclk_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  counter_trgt_q, counter_trgt_d;
  spi_mode_t             mode_q, mode_d;
  logic [BITS_WIDTH-1:0] nbits_q, nbits_d;
  logic [BITS_WIDTH:0]   edge_cnt_q, edge_cnt_d, edge_nxt;
  logic                  spi_clk_q, spi_clk_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  tc, cnt_en, cnt_clr, leading, last_edge, run, clk_after;

  assign cnt_en    = (state_q != StIdle);
  assign cnt_clr   = (state_d == StIdle);
  assign edge_nxt  = edge_cnt_q + (BITS_WIDTH + 1)'(1);
  // edge_cnt_q holds edges already made, so the pending edge is odd (leading) when it is even.
  assign leading   = ~edge_cnt_q[0];
  assign last_edge = (edge_nxt == {nbits_q, 1'b0});
  assign run       = (state_q == StRun);

  spi_master_divcnt #(
    .Width (DIV_WIDTH)
  ) u_divcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .trgt_i (div_q),
    .tc_o   (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q          <= '0;
      counter_trgt_q <= '0;
      mode_q         <= '0;
      nbits_q        <= '0;
      edge_cnt_q     <= '0;
      spi_clk_q      <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      div_q          <= div_d;
      counter_trgt_q <= counter_trgt_d;
      mode_q         <= mode_d;
      nbits_q        <= nbits_d;
      edge_cnt_q     <= edge_cnt_d;
      spi_clk_q      <= spi_clk_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  // Next-state logic: transfer setup, edge counting, completion and abort.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    mode_d         = mode_q;
    nbits_d        = nbits_q;
    edge_cnt_d     = edge_cnt_q;
    spi_clk_d      = spi_clk_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;
    counter_trgt_d = bus.clk_div_valid ? bus.clk_div : counter_trgt_q;
    clk_after      = tc ? ~spi_clk_q : spi_clk_q;
    unique case (state_q)
      StIdle: begin
        spi_clk_d = bus.cpol;
        if (bus.start) begin
          div_d      = counter_trgt_q;
          mode_d     = '{cpol: bus.cpol, cpha: bus.cpha};
          nbits_d    = bus.num_bits;
          edge_cnt_d = '0;
          if (bus.num_bits == '0) done_d = 1'b1;
          else                    state_d = StRun;
        end
      end
      StRun: begin
        if (tc) begin
          spi_clk_d  = ~spi_clk_q;
          edge_cnt_d = edge_nxt;
        end
        if (tc && last_edge) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (bus.stop) begin
          // A coincident edge has already been taken; only park if SCLK is off idle.
          if (clk_after == mode_q.cpol) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else begin
            state_d = StStopping;
          end
        end
      end
      StStopping: begin
        if (tc) begin
          spi_clk_d = ~spi_clk_q;
          state_d   = StIdle;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode: strobes come only from registered state.
  always_comb begin
    bus.spi_clk      = spi_clk_q;
    bus.spi_rise     = tc & ~spi_clk_q;
    bus.spi_fall     = tc & spi_clk_q;
    bus.sample       = tc & run & (mode_q.cpha ? ~leading : leading);
    bus.shift        = tc & run & (mode_q.cpha ? leading : (~leading & ~last_edge));
    bus.busy         = (state_q != StIdle);
    bus.done         = done_q;
    bus.aborted      = aborted_q;
    bus.counter_trgt = counter_trgt_q;
  end
endmodule

// File: tb/tb_spi_master_sclk_gen.sv
// Directed bench for spi_master_sclk_gen.
module tb_spi_master_sclk_gen;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_rise, n_fall, n_samp, n_shift;

  spi_master_sclk_gen_if #(.DIV_WIDTH(16), .BITS_WIDTH(6)) bus ();

  spi_master_sclk_gen #(
    .DIV_WIDTH  (16),
    .BITS_WIDTH (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.clk_div       = '0;
    bus.clk_div_valid = 1'b0;
    bus.cpol          = 1'b0;
    bus.cpha          = 1'b0;
    bus.num_bits      = '0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_spi_clk", 32'(bus.spi_clk), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done_abort", 32'({bus.done, bus.aborted}), 0);
    chk("rst_trgt", 32'(bus.counter_trgt), 0);
    chk("rst_strobes", 32'({bus.spi_rise, bus.spi_fall, bus.sample, bus.shift}), 0);
    rst = 1'b0;
    tick();

    // Mode 0, div 0, N=1
    bus.num_bits = 6'd1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("m0_c1_rise_sample", 32'({bus.spi_rise, bus.sample, bus.shift, bus.busy}), 32'b1101);
    tick();
    chk("m0_c2_fall_noshift", 32'({bus.spi_fall, bus.shift, bus.sample, bus.spi_clk}), 32'b1001);
    tick();
    chk("m0_c3_done", 32'({bus.done, bus.aborted, bus.spi_clk, bus.busy}), 32'b1000);

    // Mode 3, div 3, N=8
    bus.clk_div       = 16'd3;
    bus.clk_div_valid = 1'b1;
    bus.cpol          = 1'b1;
    tick();
    bus.clk_div_valid = 1'b0;
    chk("m3_trgt", 32'(bus.counter_trgt), 3);
    tick();
    chk("m3_idle_clk", 32'(bus.spi_clk), 1);
    bus.cpha     = 1'b1;
    bus.num_bits = 6'd8;
    bus.start    = 1'b1;
    n_rise = 0; n_fall = 0; n_samp = 0; n_shift = 0;
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      if (c < 65) chk("m3_edge_pos", 32'(bus.spi_rise | bus.spi_fall), 32'((c % 4) == 0));
      n_rise  += int'(bus.spi_rise);
      n_fall  += int'(bus.spi_fall);
      n_samp  += int'(bus.sample & bus.spi_rise);
      n_shift += int'(bus.shift & bus.spi_fall);
      if (c == 65) chk("m3_done", 32'({bus.done, bus.aborted, bus.busy, bus.spi_clk}), 32'b1001);
    end
    chk("m3_rises", 32'(n_rise), 8);
    chk("m3_falls", 32'(n_fall), 8);
    chk("m3_samples_on_rise", 32'(n_samp), 8);
    chk("m3_shifts_on_fall", 32'(n_shift), 8);

    // Divider reprogrammed during a div=1 transfer
    bus.clk_div       = 16'd1;
    bus.clk_div_valid = 1'b1;
    bus.cpol          = 1'b0;
    bus.cpha          = 1'b0;
    tick();
    bus.clk_div_valid = 1'b0;
    chk("dv_trgt1", 32'(bus.counter_trgt), 1);
    tick();
    bus.num_bits = 6'd2;
    bus.start    = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c < 9) chk("dv_edge_pos", 32'(bus.spi_rise | bus.spi_fall), 32'((c % 2) == 0));
      if (c == 1) begin
        bus.start         = 1'b0;
        bus.clk_div       = 16'd5;
        bus.clk_div_valid = 1'b1;
      end
      if (c == 2) begin
        bus.clk_div_valid = 1'b0;
        chk("dv_trgt5", 32'(bus.counter_trgt), 5);
      end
      if (c == 9) begin
        chk("dv_done1", 32'({bus.done, bus.busy}), 32'b10);
        bus.num_bits = 6'd1;
        bus.start    = 1'b1;
      end
    end
    for (int r = 1; r <= 13; r++) begin
      tick();
      if (r == 1) bus.start = 1'b0;
      if (r < 13) chk("dv_b2b_edge", 32'(bus.spi_rise | bus.spi_fall), 32'(r == 6 || r == 12));
      if (r == 13) chk("dv_b2b_done", 32'({bus.done, bus.aborted}), 32'b10);
    end

    // Mode 1, div 2, N=4, stop while SCLK high
    bus.clk_div       = 16'd2;
    bus.clk_div_valid = 1'b1;
    tick();
    bus.clk_div_valid = 1'b0;
    bus.cpha     = 1'b1;
    bus.num_bits = 6'd4;
    bus.start    = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      if (c == 3)
        chk("m1_lead_shift", 32'({bus.spi_rise, bus.shift, bus.sample}), 32'b110);
      if (c == 5) begin
        chk("m1_clk_high", 32'(bus.spi_clk), 1);
        bus.stop = 1'b1;
      end
      if (c == 6) begin
        bus.stop = 1'b0;
        chk("m1_stopping_fall",
            32'({bus.spi_fall, bus.sample, bus.shift, bus.busy, bus.done}), 32'b10010);
      end
      if (c == 7)
        chk("m1_abort_done", 32'({bus.done, bus.aborted, bus.spi_clk, bus.busy}), 32'b1100);
    end

    // num_bits=0, start while busy, stop in idle
    bus.cpha     = 1'b0;
    bus.num_bits = 6'd0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("z_done", 32'({bus.done, bus.aborted, bus.busy, bus.spi_rise, bus.spi_fall}), 32'b10000);
    bus.num_bits = 6'd1;
    bus.start    = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("ig_edge_pos", 32'(bus.spi_rise | bus.spi_fall), 32'(c == 3 || c == 6));
      if (c == 1) bus.start = 1'b0;
      if (c == 2) begin
        bus.num_bits = 6'd4;
        bus.start    = 1'b1;
      end
      if (c == 3) bus.start = 1'b0;
      if (c == 7) chk("ig_done", 32'({bus.done, bus.aborted, bus.busy}), 32'b100);
      if (c == 8) begin
        chk("ig_idle", 32'({bus.done, bus.busy}), 0);
        bus.stop = 1'b1;
      end
      if (c == 9) begin
        bus.stop = 1'b0;
        chk("stop_idle", 32'({bus.busy, bus.done, bus.aborted}), 0);
      end
    end

    // Reset mid-transfer with cpol=1
    bus.cpol = 1'b1;
    tick();
    chk("rm_idle_clk", 32'(bus.spi_clk), 1);
    bus.num_bits = 6'd4;
    bus.start    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      if (c == 2) begin
        chk("rm_pre_clk", 32'({bus.spi_clk, bus.busy}), 32'b11);
        rst = 1'b1;
      end
      if (c == 3) begin
        rst = 1'b0;
        chk("rm_reset_vals",
            32'({bus.spi_clk, bus.busy, bus.done, bus.aborted,
                 bus.spi_rise, bus.spi_fall, bus.sample, bus.shift}), 0);
        chk("rm_reset_trgt", 32'(bus.counter_trgt), 0);
      end
      if (c == 4) chk("rm_release", 32'({bus.spi_clk, bus.busy, bus.done}), 32'b100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
